// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads both GPR operands with write-back bypass, tracks in-flight
// destination writes in a pending scoreboard and stalls RAW/WAW hazards against them.
module operand_fetch #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 3,
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opcode,
    input  logic               in_wr,
    input  logic [RADDR_W-1:0] in_dest,
    input  logic [RADDR_W-1:0] in_src1,
    input  logic [RADDR_W-1:0] in_src2,
    output logic [RADDR_W-1:0] rf_read_addr_1,
    output logic [RADDR_W-1:0] rf_read_addr_2,
    input  logic [DATA_W-1:0]  rf_read_data_1,
    input  logic [DATA_W-1:0]  rf_read_data_2,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic               out_wr,
    output logic [RADDR_W-1:0] out_dest,
    output logic [DATA_W-1:0]  out_op_a,
    output logic [DATA_W-1:0]  out_op_b,
    output logic [STALL_W-1:0] stall_cycles,
    output logic               sb_err
);
    localparam int unsigned NumRegs = 1 << RADDR_W;

    logic [NumRegs-1:0] pending_q, pending_d;
    logic               out_valid_q, out_valid_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic               wr_q, wr_d;
    logic [RADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               sb_err_q, sb_err_d;

    logic byp_src1, byp_src2, byp_dest;
    logic hazard, accept;

    assign rf_read_addr_1 = in_src1;
    assign rf_read_addr_2 = in_src2;

    always_comb begin
        byp_src1 = wb_en && (wb_dest == in_src1);
        byp_src2 = wb_en && (wb_dest == in_src2);
        byp_dest = wb_en && (wb_dest == in_dest);
        // A write-back landing this cycle resolves the hazard it would otherwise raise.
        hazard   = (pending_q[in_src1] && !byp_src1)
                || (pending_q[in_src2] && !byp_src2)
                || (in_wr && pending_q[in_dest] && !byp_dest);
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_dest] = 1'b0;
        end
        // Set after clear so a same-register set wins.
        if (accept && in_wr) begin
            pending_d[in_dest] = 1'b1;
        end

        sb_err_d = sb_err_q || (wb_en && !pending_q[wb_dest]);

        stall_d = stall_q;
        if (in_valid && hazard && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end

        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        wr_d        = wr_q;
        dest_d      = dest_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        if (accept) begin
            out_valid_d = 1'b1;
            opcode_d    = in_opcode;
            wr_d        = in_wr;
            dest_d      = in_dest;
            op_a_d      = byp_src1 ? wb_data : rf_read_data_1;
            op_b_d      = byp_src2 ? wb_data : rf_read_data_2;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            wr_q        <= 1'b0;
            dest_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            stall_q     <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            wr_q        <= wr_d;
            dest_q      <= dest_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            stall_q     <= stall_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_opcode   = opcode_q;
    assign out_wr       = wr_q;
    assign out_dest     = dest_q;
    assign out_op_a     = op_a_q;
    assign out_op_b     = op_b_q;
    assign stall_cycles = stall_q;
    assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand sequences for reset, back-pressure,
// sb_err and stall saturation, then random traffic against a scoreboard-level model.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_wr, wb_en, out_valid, out_ready, out_wr, sb_err;
    logic [3:0]  in_opcode, out_opcode;
    logic [2:0]  in_dest, in_src1, in_src2, rf_read_addr_1, rf_read_addr_2, wb_dest, out_dest;
    logic [15:0] rf_read_data_1, rf_read_data_2, wb_data, out_op_a, out_op_b, stall_cycles;
    logic [15:0] gpr [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_wr(in_wr), .in_dest(in_dest), .in_src1(in_src1),
        .in_src2(in_src2), .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_wr(out_wr), .out_dest(out_dest), .out_op_a(out_op_a),
        .out_op_b(out_op_b), .stall_cycles(stall_cycles), .sb_err(sb_err)
    );

    // Simple GPR file: write lands at the edge, reads are combinational.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) gpr[i] <= 16'h0010 + 16'(i);
            gpr[1] <= 16'h0001;
            gpr[2] <= 16'h0001;
        end else if (wb_en) begin
            gpr[wb_dest] <= wb_data;
        end
    end
    assign rf_read_data_1 = gpr[rf_read_addr_1];
    assign rf_read_data_2 = gpr[rf_read_addr_2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [3:0] opc, input logic wb,
                         input logic [2:0] wbd, input logic [15:0] wbdat, input logic ordy);
        in_valid = v; in_wr = wr; in_dest = d; in_src1 = s1; in_src2 = s2; in_opcode = opc;
        wb_en = wb; wb_dest = wbd; wb_data = wbdat; out_ready = ordy;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_sb_err", 32'(sb_err), 32'd0);
        chk("rst_op_a", 32'(out_op_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pending probe: with out_valid low and no write-back, in_ready reflects pending[r].
    task automatic probe_pending(input string nm, input logic [2:0] r, input logic exp);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, r, r, 4'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        #1 chk(nm, 32'(in_ready), 32'(!exp));
    endtask

    typedef struct {
        logic        vld, wr;
        logic [2:0]  dest, s1, s2;
        logic        wb;
        logic [2:0]  wbd;
        logic [15:0] wbdat;
        logic        ordy;
        logic        e_rdy, e_ov;
        logic [15:0] e_a, e_b, e_stall;
    } vec_t;

    vec_t vecs [9];

    // Behavioural model state for the random phase.
    bit          m_pend [8];
    bit          m_valid, m_wr, m_err;
    logic [3:0]  m_opc;
    logic [2:0]  m_dest;
    logic [15:0] m_a, m_b;
    int          m_stall;

    function automatic bit byp(input logic [2:0] s);
        return wb_en && (wb_dest == s);
    endfunction

    initial begin
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;

        //          vld   wr    dest  s1    s2    wb    wbd   wbdat    ordy  rdy   ov    a        b        stall
        vecs[0] = '{1'b1, 1'b1, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h00, 1'b1, 1'b1, 1'b1, 16'h01, 16'h01, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 3'd4, 3'd3, 3'd1, 1'b0, 3'd0, 16'h00, 1'b1, 1'b0, 1'b0, 16'h00, 16'h00, 16'd1};
        vecs[2] = '{1'b1, 1'b1, 3'd4, 3'd3, 3'd1, 1'b1, 3'd3, 16'h42, 1'b1, 1'b1, 1'b1, 16'h42, 16'h01, 16'd1};
        vecs[3] = '{1'b1, 1'b1, 3'd4, 3'd1, 3'd1, 1'b1, 3'd4, 16'h07, 1'b1, 1'b1, 1'b1, 16'h01, 16'h01, 16'd1};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 3'd4, 3'd0, 1'b0, 3'd0, 16'h00, 1'b1, 1'b0, 1'b0, 16'h00, 16'h00, 16'd1};
        vecs[5] = '{1'b0, 1'b0, 3'd0, 3'd3, 3'd3, 1'b0, 3'd0, 16'h00, 1'b1, 1'b1, 1'b0, 16'h00, 16'h00, 16'd1};
        vecs[6] = '{1'b1, 1'b0, 3'd4, 3'd3, 3'd3, 1'b0, 3'd0, 16'h00, 1'b1, 1'b1, 1'b1, 16'h42, 16'h42, 16'd1};
        vecs[7] = '{1'b1, 1'b1, 3'd5, 3'd4, 3'd2, 1'b1, 3'd4, 16'h99, 1'b1, 1'b1, 1'b1, 16'h99, 16'h01, 16'd1};
        vecs[8] = '{1'b0, 1'b0, 3'd0, 3'd4, 3'd5, 1'b0, 3'd0, 16'h00, 1'b1, 1'b0, 1'b0, 16'h00, 16'h00, 16'd1};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].wr, vecs[i].dest, vecs[i].s1, vecs[i].s2, 4'(i),
                  vecs[i].wb, vecs[i].wbd, vecs[i].wbdat, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_raddr1", i), 32'(rf_read_addr_1), 32'(vecs[i].s1));
            chk($sformatf("v%0d_raddr2", i), 32'(rf_read_addr_2), 32'(vecs[i].s2));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_stall", i), 32'(stall_cycles), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_sb_err", i), 32'(sb_err), 32'd0);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_op_a", i), 32'(out_op_a), 32'(vecs[i].e_a));
                chk($sformatf("v%0d_op_b", i), 32'(out_op_b), 32'(vecs[i].e_b));
                chk($sformatf("v%0d_opcode", i), 32'(out_opcode), i);
                chk($sformatf("v%0d_dest", i), 32'(out_dest), 32'(vecs[i].dest));
                chk($sformatf("v%0d_wr", i), 32'(out_wr), 32'(vecs[i].wr));
            end
        end

        // Mid-stream reset with out_valid=1, pending=8'h05 and a nonzero stall count.
        do_reset();
        @(negedge clk) drive(1'b1, 1'b1, 3'd0, 3'd1, 3'd1, 4'd1, 1'b0, 3'd0, 16'd0, 1'b1);
        @(negedge clk) drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd1, 4'd2, 1'b0, 3'd0, 16'd0, 1'b1);
        @(negedge clk) drive(1'b1, 1'b1, 3'd2, 3'd1, 3'd1, 4'd3, 1'b0, 3'd0, 16'd0, 1'b1);
        @(negedge clk) idle();
        #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_stall", 32'(stall_cycles), 32'd1);
        do_reset();
        probe_pending("rst_pend0", 3'd0, 1'b0);
        probe_pending("rst_pend2", 3'd2, 1'b0);

        // Back-pressure: held outputs, no accept, no stall counting.
        @(negedge clk) drive(1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 4'd9, 1'b0, 3'd0, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) drive(1'b1, 1'b1, 3'd6, 3'd1, 3'd2, 4'd3, 1'b0, 3'd0, 16'd0, 1'b0);
            #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_opcode", 32'(out_opcode), 32'd9);
            chk("bp_dest", 32'(out_dest), 32'd5);
            chk("bp_op_a", 32'(out_op_a), 32'd1);
            chk("bp_stall", 32'(stall_cycles), 32'd0);
        end
        @(negedge clk) out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 chk("bp_release_opcode", 32'(out_opcode), 32'd3);

        // Spurious write-back raises sticky sb_err.
        do_reset();
        @(negedge clk) drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b1, 3'd6, 16'h1234, 1'b1);
        @(posedge clk);
        #1 chk("sb_err_set", 32'(sb_err), 32'd1);
        @(negedge clk) idle();
        repeat (3) @(posedge clk);
        #1 chk("sb_err_held", 32'(sb_err), 32'd1);
        do_reset();

        // Saturating stall counter.
        @(negedge clk) drive(1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        @(negedge clk) drive(1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        repeat (65534) @(posedge clk);
        #1 chk("stall_fffe", 32'(stall_cycles), 32'hFFFE);
        @(posedge clk);
        #1 chk("stall_ffff", 32'(stall_cycles), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1 chk("stall_no_wrap", 32'(stall_cycles), 32'hFFFF);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_valid = 0; m_wr = 0; m_err = 0; m_opc = '0; m_dest = '0; m_a = '0; m_b = '0;
        m_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int      npend;
            int      pick;
            bit      haz, rdy, acc;
            bit      nxt_pend [8];
            logic [2:0] wbd;
            @(negedge clk);
            npend = 0;
            for (int r = 0; r < 8; r++) npend += int'(m_pend[r]);
            in_valid  = ($urandom % 4) != 0;
            in_wr     = $urandom % 2;
            in_dest   = 3'($urandom);
            in_src1   = 3'($urandom);
            in_src2   = 3'($urandom);
            in_opcode = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            wb_data   = 16'($urandom);
            wb_en     = 1'b0;
            wbd       = 3'($urandom);
            if (npend > 0 && ($urandom % 3) == 0) begin
                pick = int'($urandom % 32'(npend));
                for (int r = 0; r < 8; r++) begin
                    if (m_pend[r]) begin
                        if (pick == 0) wbd = 3'(r);
                        pick--;
                    end
                end
                wb_en = 1'b1;
            end else if (($urandom % 64) == 0) begin
                wb_en = 1'b1;
            end
            wb_dest = wbd;
            #1;
            haz = (m_pend[in_src1] && !byp(in_src1)) || (m_pend[in_src2] && !byp(in_src2))
               || (in_wr && m_pend[in_dest] && !byp(in_dest));
            rdy = (!m_valid || out_ready) && !haz;
            acc = in_valid && rdy;
            chk("rnd_in_ready", 32'(in_ready), 32'(rdy));
            nxt_pend = m_pend;
            if (wb_en) nxt_pend[wb_dest] = 1'b0;
            if (acc && in_wr) nxt_pend[in_dest] = 1'b1;
            if (wb_en && !m_pend[wb_dest]) m_err = 1;
            if (in_valid && haz && m_stall < 65535) m_stall++;
            if (acc) begin
                m_valid = 1; m_opc = in_opcode; m_wr = in_wr; m_dest = in_dest;
                m_a = byp(in_src1) ? wb_data : gpr[in_src1];
                m_b = byp(in_src2) ? wb_data : gpr[in_src2];
            end else if (out_ready) begin
                m_valid = 0;
            end
            m_pend = nxt_pend;
            @(posedge clk);
            #1;
            chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd_stall", 32'(stall_cycles), 32'(m_stall));
            chk("rnd_sb_err", 32'(sb_err), 32'(m_err));
            if (m_valid) begin
                chk("rnd_opcode", 32'(out_opcode), 32'(m_opc));
                chk("rnd_wr", 32'(out_wr), 32'(m_wr));
                chk("rnd_dest", 32'(out_dest), 32'(m_dest));
                chk("rnd_op_a", 32'(out_op_a), 32'(m_a));
                chk("rnd_op_b", 32'(out_op_b), 32'(m_b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
